// File: rtl/ethernet_tx_scheduler_if.sv
// Transmit-path bundle between the frame requesters and the MAC TX FIFO input.
// master: the scheduler side; slave: the requesters plus MAC FIFO side.
interface ethernet_tx_scheduler_if #(
    parameter int num_req_p         = 2,
    parameter int axis_data_width_p = 64
);
    logic [num_req_p*axis_data_width_p-1:0]     req_tdata_i;
    logic [num_req_p*axis_data_width_p/8-1:0]   req_tkeep_i;
    logic [num_req_p-1:0]                       req_tvalid_i;
    logic [num_req_p-1:0]                       req_tlast_i;
    logic [num_req_p-1:0]                       req_tready_o;
    logic [axis_data_width_p-1:0]               m_axis_tdata_o;
    logic [axis_data_width_p/8-1:0]             m_axis_tkeep_o;
    logic                                       m_axis_tvalid_o;
    logic                                       m_axis_tready_i;
    logic                                       m_axis_tlast_o;
    logic                                       m_axis_tuser_o;

    modport master (
        input  req_tdata_i, req_tkeep_i, req_tvalid_i, req_tlast_i, m_axis_tready_i,
        output req_tready_o, m_axis_tdata_o, m_axis_tkeep_o, m_axis_tvalid_o,
               m_axis_tlast_o, m_axis_tuser_o
    );

    modport slave (
        output req_tdata_i, req_tkeep_i, req_tvalid_i, req_tlast_i, m_axis_tready_i,
        input  req_tready_o, m_axis_tdata_o, m_axis_tkeep_o, m_axis_tvalid_o,
               m_axis_tlast_o, m_axis_tuser_o
    );
endinterface

// File: rtl/ethernet_tx_scheduler.sv
// Whole-frame round-robin arbiter into the MAC TX FIFO; one arbitration cycle, then zero-latency pass-through.
// Owner's ready mirrors MAC ready; runaway frames are cut at max_beats_p and drained; gap_cycles_p idle after each frame.
module ethernet_tx_scheduler #(
    parameter int num_req_p         = 2,
    parameter int axis_data_width_p = 64,
    parameter int max_beats_p       = 190,
    parameter int gap_cycles_p      = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    ethernet_tx_scheduler_if.master bus,
    output logic [num_req_p-1:0]    grant_o,
    output logic                    busy_o,
    output logic [15:0]             frames_sent_o,
    output logic [15:0]             frames_trunc_o
);
    localparam int dw_lp       = axis_data_width_p;
    localparam int kw_lp       = axis_data_width_p / 8;
    localparam int pw_lp       = $clog2(num_req_p);
    localparam int bw_lp       = $clog2(max_beats_p);
    localparam int gw_lp       = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;
    localparam int gap_load_lp = (gap_cycles_p > 0) ? gap_cycles_p - 1 : 0;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_e;

    localparam state_e end_state_lp = (gap_cycles_p > 0) ? GAP : IDLE;

    state_e             state_q, state_d;
    logic [pw_lp-1:0]   ptr_q, ptr_d;
    logic [pw_lp-1:0]   grant_q, grant_d;
    logic [bw_lp-1:0]   beat_q, beat_d;
    logic [gw_lp-1:0]   gap_q, gap_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        trunc_q, trunc_d;

    logic [pw_lp-1:0]   sel;
    logic [pw_lp:0]     cand;
    logic               any_vld;
    logic [num_req_p-1:0] own_oh;
    logic               own_vld, own_last;
    logic [dw_lp-1:0]   own_dat;
    logic [kw_lp-1:0]   own_keep;
    logic [pw_lp-1:0]   ptr_next;
    logic               hs, trunc_beat;

    // Round-robin search: walk offsets from lowest priority to highest so the last hit wins.
    always_comb begin
        sel     = ptr_q;
        any_vld = 1'b0;
        cand    = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (pw_lp+1)'(i);
            if (cand >= (pw_lp+1)'(num_req_p)) begin
                cand = cand - (pw_lp+1)'(num_req_p);
            end
            for (int j = 0; j < num_req_p; j++) begin
                if (cand == (pw_lp+1)'(j) && bus.req_tvalid_i[j]) begin
                    sel     = pw_lp'(j);
                    any_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        own_oh   = '0;
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_dat  = '0;
        own_keep = '0;
        for (int j = 0; j < num_req_p; j++) begin
            if (grant_q == pw_lp'(j)) begin
                own_oh[j] = 1'b1;
                own_vld   = bus.req_tvalid_i[j];
                own_last  = bus.req_tlast_i[j];
                own_dat   = bus.req_tdata_i[j*dw_lp +: dw_lp];
                own_keep  = bus.req_tkeep_i[j*kw_lp +: kw_lp];
            end
        end
    end

    assign hs         = (state_q == XFER) & own_vld & bus.m_axis_tready_i;
    assign trunc_beat = (beat_q == bw_lp'(max_beats_p - 1)) & ~own_last;
    assign ptr_next   = (grant_q == pw_lp'(num_req_p - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            sent_q  <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            sent_q  <= sent_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        sent_d  = sent_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    grant_d = sel;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (hs) begin
                    beat_d = beat_q + 1'b1;
                    if (own_last) begin
                        sent_d  = sent_q + 16'd1;
                        ptr_d   = ptr_next;
                        gap_d   = gw_lp'(gap_load_lp);
                        state_d = end_state_lp;
                    end else if (trunc_beat) begin
                        trunc_d = trunc_q + 16'd1;
                        ptr_d   = ptr_next;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (own_vld && own_last) begin
                    gap_d   = gw_lp'(gap_load_lp);
                    state_d = end_state_lp;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so the MAC never sees a stale beat.
    always_comb begin
        bus.m_axis_tdata_o  = own_dat;
        bus.m_axis_tkeep_o  = own_keep;
        bus.m_axis_tvalid_o = 1'b0;
        bus.m_axis_tlast_o  = 1'b0;
        bus.m_axis_tuser_o  = 1'b0;
        bus.req_tready_o    = '0;
        grant_o             = '0;
        busy_o              = (state_q != IDLE);
        frames_sent_o       = sent_q;
        frames_trunc_o      = trunc_q;
        case (state_q)
            XFER: begin
                bus.m_axis_tvalid_o = own_vld;
                bus.m_axis_tlast_o  = own_vld & (own_last | trunc_beat);
                bus.m_axis_tuser_o  = own_vld & trunc_beat;
                bus.req_tready_o    = own_oh & {num_req_p{bus.m_axis_tready_i}};
                grant_o             = own_oh;
            end
            DRAIN: begin
                bus.req_tready_o = own_oh;
                grant_o          = own_oh;
            end
            default: ;
        endcase
        if (reset_i) begin
            bus.m_axis_tvalid_o = 1'b0;
            bus.m_axis_tlast_o  = 1'b0;
            bus.m_axis_tuser_o  = 1'b0;
            bus.req_tready_o    = '0;
            grant_o             = '0;
            busy_o              = 1'b0;
            frames_sent_o       = '0;
            frames_trunc_o      = '0;
        end
    end
endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// Directed bench: queued requester frames, a beat monitor, hand-derived expectations per scenario.
module tb_ethernet_tx_scheduler;
    localparam int N    = 2;
    localparam int W    = 64;
    localparam int MAXB = 4;
    localparam int GAPC = 2;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [1:0]  gnt;
        logic [15:0] sent;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [N-1:0] grant;
    logic        busy;
    logic [15:0] sent, trunc;

    always #5 clk = ~clk;

    ethernet_tx_scheduler_if #(.num_req_p(N), .axis_data_width_p(W)) bus ();

    ethernet_tx_scheduler #(
        .num_req_p(N), .axis_data_width_p(W), .max_beats_p(MAXB), .gap_cycles_p(GAPC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .bus(bus), .grant_o(grant), .busy_o(busy),
        .frames_sent_o(sent), .frames_trunc_o(trunc)
    );

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    rdy_toggle = 1'b0;
    bit    pop0, pop1, stall_v;
    beat_t stall_b;
    beat_t src0[$], src1[$], outq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int r, input int f, input int b, input bit last);
        beat_t x;
        x      = '0;
        x.dat  = {8'(r), 24'(f), 32'(b)};
        x.keep = last ? 8'h0F : 8'hFF;
        x.last = last;
        return x;
    endfunction

    task automatic push_frame(input int r, input int f, input int nb);
        for (int b = 0; b < nb; b++) begin
            if (r == 0) src0.push_back(mk(r, f, b, b == nb - 1));
            else        src1.push_back(mk(r, f, b, b == nb - 1));
        end
    endtask

    task automatic drive();
        beat_t b0, b1;
        if (pop0 && src0.size() != 0) void'(src0.pop_front());
        if (pop1 && src1.size() != 0) void'(src1.pop_front());
        pop0 = 1'b0;
        pop1 = 1'b0;
        b0 = (src0.size() != 0) ? src0[0] : '0;
        b1 = (src1.size() != 0) ? src1[0] : '0;
        bus.req_tvalid_i    = {src1.size() != 0, src0.size() != 0};
        bus.req_tlast_i     = {b1.last, b0.last};
        bus.req_tdata_i     = {b1.dat, b0.dat};
        bus.req_tkeep_i     = {b1.keep, b0.keep};
        bus.m_axis_tready_i = rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
    endtask

    task automatic sample();
        beat_t o;
        pop0 = bus.req_tvalid_i[0] & bus.req_tready_o[0];
        pop1 = bus.req_tvalid_i[1] & bus.req_tready_o[1];
        o.dat  = bus.m_axis_tdata_o;
        o.keep = bus.m_axis_tkeep_o;
        o.last = bus.m_axis_tlast_o;
        o.user = bus.m_axis_tuser_o;
        o.gnt  = grant;
        o.sent = sent;
        if (stall_v) begin
            chk("stall_dat", o.dat, stall_b.dat);
            chk("stall_ctl", {bus.m_axis_tvalid_o, o.keep, o.last}, {1'b1, stall_b.keep, stall_b.last});
        end
        stall_v = bus.m_axis_tvalid_o & ~bus.m_axis_tready_i;
        stall_b = o;
        if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) outq.push_back(o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, {bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.m_axis_tuser_o}, 3'b000);
        chk({tag, "_rdy"}, bus.req_tready_o, 2'b00);
        chk({tag, "_gnt_busy"}, {grant, busy}, 3'b000);
        chk({tag, "_cnt"}, {sent, trunc}, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(negedge clk);
        chk_zero(tag);
        src0.delete();
        src1.delete();
        outq.delete();
        pop0 = 1'b0;
        pop1 = 1'b0;
        stall_v = 1'b0;
        rdy_toggle = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input bit bp_chk);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            if (bp_chk && grant[1]) begin
                chk("bp_rdy1", bus.req_tready_o, {bus.m_axis_tready_i, 1'b0});
            end
            done = (src0.size() == 0) && (src1.size() == 0) && !busy && !pop0 && !pop1;
        end
        if (!done) chk("timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        beat_t e;
        bus.req_tvalid_i = '0;
        bus.req_tlast_i = '0;
        bus.req_tdata_i = '0;
        bus.req_tkeep_i = '0;
        bus.m_axis_tready_i = 1'b0;

        // Reset state, then a single 3-beat frame from req0 with exact cycle timing.
        do_reset("rst_init");
        push_frame(0, 1, 3);
        step();
        chk("s1_arb_cycle", {grant, bus.m_axis_tvalid_o, bus.req_tready_o}, 5'b00000);
        step();
        chk("s1_grant", {grant, busy, bus.m_axis_tvalid_o}, 4'b0111);
        step();
        step();
        step();
        chk("s1_gap1", {busy, grant, sent}, {1'b1, 2'b00, 16'd1});
        step();
        chk("s1_gap2", busy, 1'b1);
        step();
        chk("s1_idle", busy, 1'b0);
        chk("s1_nbeats", outq.size(), 3);
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            e = mk(0, 1, i, i == 2);
            chk("s1_beat", {outq[i].dat, outq[i].keep, outq[i].last, outq[i].user},
                {e.dat, e.keep, e.last, 1'b0});
        end

        // Round-robin between two continuously offered 2-beat streams.
        do_reset("rst_rr");
        push_frame(0, 1, 2); push_frame(0, 2, 2);
        push_frame(1, 1, 2); push_frame(1, 2, 2);
        run_until_idle(200, 1'b0);
        chk("rr_nbeats", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            e = mk((i / 2) % 2, (i / 4) + 1, i % 2, (i % 2) == 1);
            chk("rr_beat", {outq[i].dat, outq[i].last}, {e.dat, e.last});
            chk("rr_gnt", outq[i].gnt, ((i / 2) % 2) ? 2'b10 : 2'b01);
        end
        chk("rr_sent", sent, 16'd4);

        // Backpressure on a 4-beat req1 frame; tlast lands exactly on the last allowed beat.
        do_reset("rst_bp");
        rdy_toggle = 1'b1;
        push_frame(1, 7, 4);
        run_until_idle(200, 1'b1);
        chk("bp_nbeats", outq.size(), 4);
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            e = mk(1, 7, i, i == 3);
            chk("bp_beat", {outq[i].dat, outq[i].keep, outq[i].last, outq[i].user},
                {e.dat, e.keep, e.last, 1'b0});
        end
        chk("bp_counts", {sent, trunc}, {16'd1, 16'd0});

        // Truncation of a 6-beat req0 frame; req1 waiting gets the next grant.
        do_reset("rst_tr");
        push_frame(0, 3, 6);
        push_frame(1, 4, 2);
        run_until_idle(200, 1'b0);
        chk("tr_nbeats", outq.size(), 6);
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            e = mk(0, 3, i, 1'b0);
            chk("tr_beat", {outq[i].dat, outq[i].keep, outq[i].last, outq[i].user},
                {e.dat, 8'hFF, i == 3, i == 3});
        end
        if (outq.size() >= 6) begin
            e = mk(1, 4, 0, 1'b0);
            chk("tr_next", {outq[4].dat, outq[4].gnt, outq[4].sent}, {e.dat, 2'b10, 16'd0});
            chk("tr_next_last", {outq[5].last, outq[5].user}, 2'b10);
        end
        chk("tr_counts", {sent, trunc}, {16'd1, 16'd1});

        // Reset in the middle of a req1 frame while the pointer favours req1.
        do_reset("rst_m0");
        push_frame(0, 5, 1);
        run_until_idle(50, 1'b0);
        push_frame(1, 6, 3);
        step();
        step();
        chk("mid_owner", {grant, bus.m_axis_tvalid_o}, 3'b101);
        do_reset("rst_mid");
        push_frame(0, 8, 1);
        push_frame(1, 8, 1);
        run_until_idle(50, 1'b0);
        chk("mid_nbeats", outq.size(), 2);
        if (outq.size() >= 2) begin
            chk("mid_first", outq[0].gnt, 2'b01);
            chk("mid_second", outq[1].gnt, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ethernet_tx_scheduler.md
# ethernet_tx_scheduler

Frame-level arbiter that shares the single transmit AXI-Stream path into the Ethernet MAC FIFO between `num_req_p` frame sources, for example the MMIO frame writer and a future DMA engine. It grants whole frames round-robin and never interleaves beats of two frames. It truncates runaway frames at `max_beats_p`, drains the remainder, and enforces a programmable idle gap between frames. It sits between the frame producers and the `eth_mac_mii_fifo` TX input, all in the core clock domain.

## Interface
- `num_req_p`, default 2: number of requesters; must be at least 2.
- `axis_data_width_p`, default 64: AXIS data width in bits.
- `max_beats_p`, default 190: maximum beats per frame (1518 B / 8 B); must be at least 2.
- `gap_cycles_p`, default 2: idle cycles inserted after each frame end; 0 is legal.
- `clk_i` in 1: core clock.
- `reset_i` in 1: synchronous, active-high reset.
- `req_tdata_i` in `num_req_p*axis_data_width_p`: per-requester data, requester 0 in the LSBs.
- `req_tkeep_i` in `num_req_p*axis_data_width_p/8`: per-requester byte keep.
- `req_tvalid_i` in `num_req_p`: per-requester beat valid.
- `req_tlast_i` in `num_req_p`: per-requester last beat.
- `req_tready_o` out `num_req_p`: per-requester ready.
- `m_axis_tdata_o` out `axis_data_width_p`: data to the MAC TX FIFO.
- `m_axis_tkeep_o` out `axis_data_width_p/8`: byte keep.
- `m_axis_tvalid_o` out 1: beat valid.
- `m_axis_tready_i` in 1: MAC FIFO ready.
- `m_axis_tlast_o` out 1: last beat.
- `m_axis_tuser_o` out 1: bad-frame flag, asserted only on a forced (truncated) last beat.
- `grant_o` out `num_req_p`: one-hot owner; zero when no requester owns the path.
- `busy_o` out 1: high in any state other than IDLE.
- `frames_sent_o` out 16: count of normally terminated frames; wraps at 2^16.
- `frames_trunc_o` out 16: count of truncated frames; wraps at 2^16.

## Operation
- FSM states: IDLE, XFER, DRAIN, GAP.
- Beat counter width is `$clog2(max_beats_p)`.
- Round-robin pointer `ptr_r` (width `$clog2(num_req_p)`) holds the highest-priority requester.

**IDLE**
- If any `req_tvalid_i` is set, select the first valid requester searching from `ptr_r` upward with wrap.
- Register the selection into `grant_r`, clear the beat counter, and go to XFER.
- All `req_tready_o` are 0 in IDLE. No beat is accepted in the arbitration cycle.

**XFER** (owner g = `grant_r`)
- The datapath is combinational pass-through: `m_axis_tvalid_o = req_tvalid_i[g]`; data, keep and last come from requester g.
- `req_tready_o[g] = m_axis_tready_i`; all other readies are 0.
- A handshake is `m_axis_tvalid_o & m_axis_tready_i`. Each handshake increments the beat counter.
- Handshake with `req_tlast_i[g]`:
  - increment `frames_sent_o`;
  - set `ptr_r` to (g+1) mod `num_req_p`;
  - go to GAP, or to IDLE if `gap_cycles_p` is 0.
- Handshake on beat `max_beats_p-1` (the counter equals `max_beats_p-1`) without `req_tlast_i[g]`:
  - drive `m_axis_tlast_o=1` and `m_axis_tuser_o=1` on that beat; `tkeep` is unchanged;
  - increment `frames_trunc_o`;
  - set `ptr_r` to (g+1) mod `num_req_p`;
  - go to DRAIN.
- If tlast arrives on exactly beat `max_beats_p-1`, the frame ends normally: `tuser` stays 0 and no truncation is counted.
- `m_axis_tuser_o` is 0 in every other case.

**DRAIN**
- `req_tready_o[g]=1` and `m_axis_tvalid_o=0`. Requester g's beats are discarded.
- On `req_tvalid_i[g] & req_tlast_i[g]`, go to GAP, or to IDLE if `gap_cycles_p` is 0.

**GAP**
- Load a down-counter with `gap_cycles_p` on entry. Hold every `req_tready_o` and `m_axis_tvalid_o` at 0.
- Go to IDLE when the counter reaches 0. The total GAP duration is exactly `gap_cycles_p` cycles.

**Outputs and reset**
- `grant_o` is the one-hot of `grant_r` in XFER and DRAIN, and 0 otherwise.
- Reset values: state IDLE, `ptr_r=0`, `grant_r=0`, both counters 0.
- All outputs are 0 during and right after reset, except `m_axis_tdata_o` and `m_axis_tkeep_o`, which are don't-care while `m_axis_tvalid_o` is 0.
- Reset mid-frame abandons the frame with no tlast emitted. The MAC FIFO shares `reset_i` and discards its partial frame.

## Timing
- Arbitration latency: `req_tvalid_i` seen in IDLE at cycle t gives the first possible beat at cycle t+1.
- Throughput within a frame is one beat per cycle while valid and ready both hold.
- Frame-to-frame overhead: `gap_cycles_p` + 1 cycles from the tlast handshake to the next possible first beat.
- Requester valids that change during XFER, DRAIN or GAP do not alter `grant_r`.
- The AXIS rule holds: while `m_axis_tvalid_o=1` and `m_axis_tready_i=0`, outputs track the owner's stable inputs. Requesters must not retract valid.
- Counter wrap: 16'hFFFF + 1 = 16'h0000, with no saturation.

## Test plan
- **Single frame:** req0 sends 3 beats, tlast on beat 3, tready=1 → grant_o=2'b01 one cycle after valid; 3 beats out unchanged; frames_sent_o=1; idle 2 cycles; busy_o low after the gap.
- **Round-robin:** req0 and req1 both hold continuous 2-beat frames → grant order is 0,1,0,1; no interleaving; after 4 frames frames_sent_o=4.
- **Backpressure:** tready toggles 1,0,1,0 during a 4-beat frame from req1 → data, keep and last are held stable while stalled; exactly 4 handshakes; req_tready_o[1] mirrors tready.
- **Truncation:** max_beats_p=4, req0 sends 6 beats, tlast on beat 6 → 4 beats out, beat 4 carries tlast=1 and tuser=1; beats 5-6 drained with m_axis_tvalid_o=0; frames_trunc_o=1, frames_sent_o=0; next grant goes to req1 if it is valid.
- **Boundary:** max_beats_p=4, frame with tlast on beat 4 → tuser=0 and frames_sent_o increments. Separately, reset asserted mid-XFER → next cycle all outputs are 0 and ptr_r=0, and req1 wins no priority over req0.
